uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-port round-robin arbiter feeding a single UART transmitter.
// One byte per grant, then waits for the transmitter's busy cycle and an idle gap.
module uart_tx_arbiter #(
    parameter int IDLE_GAP     = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_data,
    output logic       o_req0_ack,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_data,
    output logic       o_req1_ack,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_en,
    output logic       o_busy,
    output logic       o_grant,
    output logic       o_err_timeout,
    input  logic       i_clr_err,
    output logic [1:0] o_dbg_state
);

    // Handshake: a requester holds valid and data stable until it sees a
    // one-cycle ack; requests are only sampled in IDLE, nothing is buffered.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_en_q, tx_en_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       grant_q, grant_d;
    logic       ptr_q, ptr_d;
    logic       err_q, err_d;
    logic [3:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0] gap_cnt_q, gap_cnt_d;
    logic       pick;
    logic       err_set;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;
        pick      = 1'b0;
        err_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req0_valid || i_req1_valid) begin
                    // Both pending: pointer decides; otherwise the lone requester wins.
                    pick      = (i_req0_valid && i_req1_valid) ? ptr_q : i_req1_valid;
                    state_d   = ST_SEND;
                    tx_data_d = pick ? i_req1_data : i_req0_data;
                    tx_en_d   = 1'b1;
                    ack0_d    = ~pick;
                    ack1_d    = pick;
                    grant_d   = pick;
                    ptr_d     = ~pick;
                end
            end
            ST_SEND: begin
                state_d   = ST_WAIT_BUSY;
                tmo_cnt_d = 4'd0;
            end
            ST_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = 3'd0;
                end else if (tmo_cnt_q == 4'(BUSY_TIMEOUT - 1)) begin
                    err_set   = 1'b1;
                    state_d   = ST_GAP;
                    gap_cnt_d = 3'd0;
                    tmo_cnt_d = 4'd0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 4'd1;
                end
            end
            ST_GAP: begin
                // Only an unbroken run of idle cycles releases the arbiter.
                if (i_tx_busy) begin
                    gap_cnt_d = 3'd0;
                end else if (gap_cnt_q == 3'(IDLE_GAP - 1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = 3'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_set) begin
            err_d = 1'b1;
        end else if (i_clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            grant_q   <= 1'b0;
            ptr_q     <= 1'b0;
            err_q     <= 1'b0;
            tmo_cnt_q <= 4'd0;
            gap_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign o_tx_data     = tx_data_q;
    assign o_tx_en       = tx_en_q;
    assign o_req0_ack    = ack0_q;
    assign o_req1_ack    = ack1_q;
    assign o_grant       = grant_q;
    assign o_err_timeout = err_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle-by-cycle vector table followed
// by hand-written sequences for gap glitches, mid-transfer reset and dropped requests.
module tb_uart_tx_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_req0_valid, i_req1_valid;
  logic [7:0] i_req0_data, i_req1_data;
  logic       o_req0_ack, o_req1_ack;
  logic       i_tx_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_en, o_busy, o_grant, o_err_timeout;
  logic       i_clr_err;
  logic [1:0] o_dbg_state;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.IDLE_GAP(3), .BUSY_TIMEOUT(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .i_req0_data  (i_req0_data),
    .o_req0_ack   (o_req0_ack),
    .i_req1_valid (i_req1_valid),
    .i_req1_data  (i_req1_data),
    .o_req1_ack   (o_req1_ack),
    .i_tx_busy    (i_tx_busy),
    .o_tx_data    (o_tx_data),
    .o_tx_en      (o_tx_en),
    .o_busy       (o_busy),
    .o_grant      (o_grant),
    .o_err_timeout(o_err_timeout),
    .i_clr_err    (i_clr_err),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst, v0, v1, busy, clr;
    logic [7:0] d0, d1;
    logic       en;
    logic [7:0] data;
    logic       a0, a1, ob, g, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, v0, v1, busy, clr,
                              input logic [7:0] d0, d1,
                              input logic en, input logic [7:0] data,
                              input logic a0, a1, ob, g, err);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.busy = busy; v.clr = clr;
    v.d0 = d0; v.d1 = d1; v.en = en; v.data = data;
    v.a0 = a0; v.a1 = a1; v.ob = ob; v.g = g; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic en, input logic [7:0] data,
                            input logic a0, a1, ob, g, err);
    chk({tag, " tx_en"}, {7'd0, o_tx_en}, {7'd0, en});
    chk({tag, " tx_data"}, o_tx_data, data);
    chk({tag, " ack0"}, {7'd0, o_req0_ack}, {7'd0, a0});
    chk({tag, " ack1"}, {7'd0, o_req1_ack}, {7'd0, a1});
    chk({tag, " busy"}, {7'd0, o_busy}, {7'd0, ob});
    chk({tag, " grant"}, {7'd0, o_grant}, {7'd0, g});
    chk({tag, " err"}, {7'd0, o_err_timeout}, {7'd0, err});
  endtask

  // driver: inputs change 1 time unit after the active edge, outputs are read there too
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic busy, input logic clr);
    i_req0_valid = v0; i_req0_data = d0;
    i_req1_valid = v1; i_req1_data = d1;
    i_tx_busy = busy; i_clr_err = clr;
  endtask

  initial begin
    // rst v0 v1 bsy clr  d0     d1      en  data   a0 a1 ob g err
    // single port-0 byte, busy high two cycles
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h31, 8'h00, 1, 8'h31, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h31, 8'h00, 0, 8'h31, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h31, 8'h00, 0, 8'h31, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h31, 8'h00, 0, 8'h31, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h31, 8'h00, 0, 8'h31, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h31, 8'h00, 0, 8'h31, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h31, 8'h00, 0, 8'h31, 0, 0, 0, 0, 0));
    // reset, then both ports valid continuously: AA, 55, AA
    vecs.push_back(mk(1, 1, 1, 0, 0, 8'hAA, 8'h55, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 1, 8'hAA, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 1, 8'h55, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 0, 8'h55, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 8'hAA, 8'h55, 0, 8'h55, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 0, 8'h55, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 0, 8'h55, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 0, 8'h55, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'hAA, 8'h55, 1, 8'hAA, 1, 0, 1, 0, 0));
    // busy never rises: timeout on the 4th WAIT_BUSY cycle, then clear
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'hAA, 8'h55, 0, 8'hAA, 0, 0, 0, 0, 0));
    // port-1 byte, timeout coincides with clear: set wins
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h7E, 1, 8'h7E, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h7E, 0, 8'h7E, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h7E, 0, 8'h7E, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h7E, 0, 8'h7E, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h7E, 0, 8'h7E, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h7E, 0, 8'h7E, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h7E, 0, 8'h7E, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h7E, 0, 8'h7E, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h7E, 0, 8'h7E, 0, 0, 0, 1, 1));

    // reset block
    i_rst = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 0, 0);
    tick();
    tick();
    expect_out("reset", 0, 8'h00, 0, 0, 0, 0, 0);
    chk("reset state", {6'd0, o_dbg_state}, 8'h00);
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      i_rst = vecs[i].rst;
      drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].busy, vecs[i].clr);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].data,
                 vecs[i].a0, vecs[i].a1, vecs[i].ob, vecs[i].g, vecs[i].err);
    end
    i_rst = 1'b0;

    // gap glitch: port 1 waits through the whole gap and is granted only after 3 clean lows
    drive(1, 8'h31, 0, 8'h00, 0, 0); tick(); expect_out("g send", 1, 8'h31, 1, 0, 1, 0, 1);
    drive(0, 8'h31, 1, 8'h99, 0, 0); tick(); expect_out("g wait", 0, 8'h31, 0, 0, 1, 0, 1);
    drive(0, 8'h31, 1, 8'h99, 1, 0); tick(); expect_out("g gap0", 0, 8'h31, 0, 0, 1, 0, 1);
    drive(0, 8'h31, 1, 8'h99, 0, 0); tick(); expect_out("g low1", 0, 8'h31, 0, 0, 1, 0, 1);
    tick();                                   expect_out("g low2", 0, 8'h31, 0, 0, 1, 0, 1);
    drive(0, 8'h31, 1, 8'h99, 1, 0); tick(); expect_out("g glitch", 0, 8'h31, 0, 0, 1, 0, 1);
    drive(0, 8'h31, 1, 8'h99, 0, 0); tick(); expect_out("g relow1", 0, 8'h31, 0, 0, 1, 0, 1);
    tick();                                   expect_out("g relow2", 0, 8'h31, 0, 0, 1, 0, 1);
    tick();                                   expect_out("g idle", 0, 8'h31, 0, 0, 0, 0, 1);
    tick();                                   expect_out("g next", 1, 8'h99, 0, 1, 1, 1, 1);
    drive(0, 8'h00, 0, 8'h00, 0, 0);  tick(); expect_out("r wait", 0, 8'h99, 0, 0, 1, 1, 1);

    // asynchronous reset in WAIT_BUSY, checked before any clock edge
    #2;
    i_rst = 1'b1;
    #1;
    expect_out("async rst", 0, 8'h00, 0, 0, 0, 0, 0);
    chk("async rst state", {6'd0, o_dbg_state}, 8'h00);
    tick();
    expect_out("rst held", 0, 8'h00, 0, 0, 0, 0, 0);
    i_rst = 1'b0;
    drive(0, 8'h00, 1, 8'h7E, 0, 0); tick(); expect_out("r send", 1, 8'h7E, 0, 1, 1, 1, 0);
    drive(0, 8'h00, 0, 8'h7E, 0, 0); tick(); expect_out("r wait2", 0, 8'h7E, 0, 0, 1, 1, 0);
    drive(0, 8'h00, 0, 8'h7E, 1, 0); tick(); expect_out("r gap", 0, 8'h7E, 0, 0, 1, 1, 0);

    // port 1 raised during the gap and dropped before IDLE: no grant ever
    drive(0, 8'h00, 1, 8'h42, 0, 0); tick(); expect_out("d gap1", 0, 8'h7E, 0, 0, 1, 1, 0);
    tick();                                   expect_out("d gap2", 0, 8'h7E, 0, 0, 1, 1, 0);
    drive(0, 8'h00, 0, 8'h42, 0, 0); tick(); expect_out("d idle", 0, 8'h7E, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("d quiet%0d", k), 0, 8'h7E, 0, 0, 0, 1, 0);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
